// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the TinyChip instruction store.
// Optional parity storage is enabled with INSTR_PARITY_EN.
package instr_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN
   } state_e;

   localparam int IW_DEF = 9;
   localparam int AW_DEF = 8;

   localparam logic [IW_DEF-1:0] NOP_WORD_DEF = '0;

   // Even parity bit: makes the total count of ones even.
   function automatic logic even_par(input logic [63:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Simple dual-port RAM: synchronous write, registered 1-cycle read.
// The read register only updates on re, so rdata holds between reads.
module instr_mem_array
   import instr_mem_pkg::*;
#(
   parameter int W  = IW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [2**AW];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Loadable instruction store with valid/ready fetch port and done flag.
// Define INSTR_PARITY_EN to store and check an even-parity bit per word.
module instr_fetch_mem
   import instr_mem_pkg::*;
#(
   parameter int            IW       = IW_DEF,
   parameter int            AW       = AW_DEF,
   parameter logic [IW-1:0] NOP_WORD = IW'(NOP_WORD_DEF)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_start,
   input  logic          load_valid,
   input  logic          load_last,
   input  logic [IW-1:0] load_data,
   output logic          load_ready,
   input  logic          req_valid,
   input  logic [AW-1:0] req_addr,
   output logic          req_ready,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [IW-1:0] resp_instr,
   output logic [AW-1:0] resp_addr,
   output logic          resp_err,
   output logic [AW:0]   prog_len,
   output logic          done,
   output logic          parity_err
);

`ifdef INSTR_PARITY_EN
   localparam int MW = IW + 1;
`else
   localparam int MW = IW;
`endif

   localparam logic [AW-1:0] PTR_MAX = '1;

   state_e        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW:0]   prog_len_q, prog_len_d;
   logic          resp_valid_q, resp_valid_d;
   logic [AW-1:0] resp_addr_q, resp_addr_d;
   logic          resp_oor_q, resp_oor_d;
   logic          resp_mem_q, resp_mem_d;
   logic          done_q, done_d;
   logic          perr_q, perr_d;

   logic          fetch_en;
   logic          accept;
   logic          consume;
   logic          oor;
   logic          ld_we;
   logic          ld_fin;
   logic          par_bad;
   logic [MW-1:0] wr_word;
   logic [MW-1:0] rd_word;

`ifdef INSTR_PARITY_EN
   always_comb begin
      wr_word = {even_par(64'(load_data)), load_data};
      par_bad = rd_word[IW] != even_par(64'(rd_word[IW-1:0]));
   end
`else
   always_comb begin
      wr_word = load_data;
      par_bad = 1'b0;
   end
`endif

   instr_mem_array #(
      .W  (MW),
      .AW (AW)
   ) u_mem (
      .clk   (clk),
      .we    (ld_we),
      .waddr (ptr_q),
      .wdata (wr_word),
      .re    (accept),
      .raddr (req_addr),
      .rdata (rd_word)
   );

   // Fetches are served whenever no load is in progress (IDLE included,
   // where prog_len is 0 so every fetch reports out of range).
   always_comb begin
      fetch_en   = reset && (state_q != LOAD);
      load_ready = reset && (state_q == LOAD);
      req_ready  = fetch_en && !load_start
                   && (!resp_valid_q || resp_ready);
      accept     = req_valid && req_ready;
      consume    = resp_valid_q && resp_ready;
      oor        = {1'b0, req_addr} >= prog_len_q;
      ld_we      = (state_q == LOAD) && load_valid && !load_start;
      ld_fin     = ld_we && (load_last || (ptr_q == PTR_MAX));
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      prog_len_d   = prog_len_q;
      resp_valid_d = resp_valid_q;
      resp_addr_d  = resp_addr_q;
      resp_oor_d   = resp_oor_q;
      resp_mem_d   = resp_mem_q;
      done_d       = done_q;
      perr_d       = perr_q
                     | (resp_valid_q && resp_mem_q && par_bad);

      if (accept) begin
         resp_valid_d = 1'b1;
         resp_addr_d  = req_addr;
         resp_oor_d   = oor;
         resp_mem_d   = !oor;
         if (oor) begin
            done_d = 1'b1;
         end
      end else if (consume) begin
         resp_valid_d = 1'b0;
      end

      if (load_start) begin
         state_d      = LOAD;
         ptr_d        = '0;
         prog_len_d   = '0;
         done_d       = 1'b1;
         resp_valid_d = 1'b0;
         perr_d       = 1'b0;
      end else if (ld_we) begin
         ptr_d = ptr_q + AW'(1);
         if (ld_fin) begin
            state_d    = RUN;
            ptr_d      = '0;
            prog_len_d = {1'b0, ptr_q} + (AW+1)'(1);
            done_d     = 1'b0;
         end
      end

      if (state_q == LOAD) begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         prog_len_q   <= '0;
         resp_valid_q <= 1'b0;
         resp_addr_q  <= '0;
         resp_oor_q   <= 1'b0;
         resp_mem_q   <= 1'b0;
         done_q       <= 1'b1;
         perr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         prog_len_q   <= prog_len_d;
         resp_valid_q <= resp_valid_d;
         resp_addr_q  <= resp_addr_d;
         resp_oor_q   <= resp_oor_d;
         resp_mem_q   <= resp_mem_d;
         done_q       <= done_d;
         perr_q       <= perr_d;
      end
   end

   always_comb begin
      resp_valid = resp_valid_q;
      resp_addr  = resp_addr_q;
      resp_err   = resp_oor_q | (resp_mem_q & par_bad);
      prog_len   = prog_len_q;
      done       = done_q;
      parity_err = perr_q;
      if (resp_mem_q) begin
         resp_instr = rd_word[IW-1:0];
      end else if (resp_oor_q) begin
         resp_instr = NOP_WORD;
      end else begin
         resp_instr = '0;
      end
   end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed self-checking bench for instr_fetch_mem.
// Inputs change after posedge / at negedge; outputs are sampled at negedge.
module tb_instr_fetch_mem;
   import instr_mem_pkg::*;

   localparam int IW = 9;
   localparam int AW = 8;

   logic          clk;
   logic          reset;
   logic          load_start;
   logic          load_valid;
   logic          load_last;
   logic [IW-1:0] load_data;
   logic          load_ready;
   logic          req_valid;
   logic [AW-1:0] req_addr;
   logic          req_ready;
   logic          resp_valid;
   logic          resp_ready;
   logic [IW-1:0] resp_instr;
   logic [AW-1:0] resp_addr;
   logic          resp_err;
   logic [AW:0]   prog_len;
   logic          done;
   logic          parity_err;

   int n_chk  = 0;
   int n_fail = 0;

   logic [IW-1:0] prog1 [4];

   instr_fetch_mem #(
      .IW (IW),
      .AW (AW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_last  (load_last),
      .load_data  (load_data),
      .load_ready (load_ready),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_instr (resp_instr),
      .resp_addr  (resp_addr),
      .resp_err   (resp_err),
      .prog_len   (prog_len),
      .done       (done),
      .parity_err (parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   initial begin
      prog1[0] = 9'h10F;
      prog1[1] = 9'h10F;
      prog1[2] = 9'h1AB;
      prog1[3] = 9'h0A9;

      reset      = 1'b0;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_last  = 1'b0;
      load_data  = '0;
      req_valid  = 1'b1;
      req_addr   = '0;
      resp_ready = 1'b1;

      // Reset held for two edges
      tick();
      tick();
      settle();
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_prog_len", 32'(prog_len), 0);
      chk("rst_done", 32'(done), 1);
      chk("rst_load_ready", 32'(load_ready), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_resp_instr", 32'(resp_instr), 0);
      chk("rst_resp_err", 32'(resp_err), 0);
      req_valid = 1'b0;
      reset     = 1'b1;

      // Load a 4-word program
      tick();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = prog1[i];
         load_last  = (i == 3);
         if (i == 0) begin
            settle();
            chk("load_ready_in_load", 32'(load_ready), 1);
            chk("req_ready_in_load", 32'(req_ready), 0);
         end
         tick();
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      settle();
      chk("prog_len_4", 32'(prog_len), 4);
      chk("done_after_load", 32'(done), 0);
      chk("load_ready_run", 32'(load_ready), 0);

      // Single fetch of addr 2
      req_valid = 1'b1;
      req_addr  = 8'd2;
      chk("req_ready_run", 32'(req_ready), 1);
      tick();
      req_valid = 1'b0;
      settle();
      chk("f2_valid", 32'(resp_valid), 1);
      chk("f2_instr", 32'(resp_instr), 32'h1AB);
      chk("f2_addr", 32'(resp_addr), 2);
      chk("f2_err", 32'(resp_err), 0);

      // Back-to-back fetches 0..3
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1;
         req_addr  = AW'(i);
         tick();
         settle();
         chk("b2b_valid", 32'(resp_valid), 1);
         chk("b2b_addr", 32'(resp_addr), 32'(i));
         chk("b2b_instr", 32'(resp_instr), 32'(prog1[i]));
         chk("b2b_req_ready", 32'(req_ready), 1);
      end
      req_valid = 1'b0;
      tick();
      settle();
      chk("b2b_drain", 32'(resp_valid), 0);

      // Backpressure on addr 1 for 3 cycles
      req_valid = 1'b1;
      req_addr  = 8'd1;
      tick();
      resp_ready = 1'b0;
      req_addr   = 8'd3;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("bp_instr", 32'(resp_instr), 32'h10F);
         chk("bp_addr", 32'(resp_addr), 1);
         chk("bp_valid", 32'(resp_valid), 1);
         chk("bp_req_ready", 32'(req_ready), 0);
         tick();
      end
      resp_ready = 1'b1;
      settle();
      chk("bp_release_ready", 32'(req_ready), 1);
      tick();
      req_valid = 1'b0;
      settle();
      chk("bp_next_addr", 32'(resp_addr), 3);
      chk("bp_next_instr", 32'(resp_instr), 32'h0A9);

      // Out-of-range fetch at addr == prog_len
      req_valid = 1'b1;
      req_addr  = 8'd4;
      tick();
      req_valid = 1'b0;
      settle();
      chk("oor_valid", 32'(resp_valid), 1);
      chk("oor_instr", 32'(resp_instr), 0);
      chk("oor_err", 32'(resp_err), 1);
      chk("oor_done", 32'(done), 1);
      tick();
      settle();
      chk("oor_done_sticky", 32'(done), 1);
      chk("oor_consumed", 32'(resp_valid), 0);

      // Reload a 2-word program; done stays high until it completes
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      settle();
      chk("reload_done", 32'(done), 1);
      chk("reload_prog_len", 32'(prog_len), 0);
      load_valid = 1'b1;
      load_data  = 9'h055;
      tick();
      load_data  = 9'h1FF;
      load_last  = 1'b1;
      settle();
      chk("reload_mid_done", 32'(done), 1);
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      settle();
      chk("reload_prog_len2", 32'(prog_len), 2);
      chk("reload_done_clr", 32'(done), 0);

      req_valid = 1'b1;
      req_addr  = 8'd1;
      tick();
      req_addr = 8'd2;
      settle();
      chk("r2_instr", 32'(resp_instr), 32'h1FF);
      chk("r2_err", 32'(resp_err), 0);
      tick();
      req_valid = 1'b0;
      settle();
      chk("r2_oor_err", 32'(resp_err), 1);
      chk("r2_oor_addr", 32'(resp_addr), 2);
      chk("r2_oor_done", 32'(done), 1);
      tick();

      // load_start beats a simultaneous request
      req_valid  = 1'b1;
      req_addr   = 8'd0;
      load_start = 1'b1;
      settle();
      chk("ls_req_ready", 32'(req_ready), 0);
      tick();
      req_valid  = 1'b0;
      load_start = 1'b0;
      settle();
      chk("ls_in_load", 32'(load_ready), 1);
      chk("ls_no_resp", 32'(resp_valid), 0);
      chk("ls_addr_kept", 32'(resp_addr), 2);

      // Reset in the middle of a load
      load_valid = 1'b1;
      load_data  = 9'h123;
      tick();
      load_valid = 1'b0;
      reset      = 1'b0;
      tick();
      reset = 1'b1;
      settle();
      chk("mid_rst_prog_len", 32'(prog_len), 0);
      chk("mid_rst_done", 32'(done), 1);
      chk("mid_rst_load_ready", 32'(load_ready), 0);
      req_valid = 1'b1;
      req_addr  = 8'd0;
      chk("mid_rst_req_ready", 32'(req_ready), 1);
      tick();
      req_valid = 1'b0;
      settle();
      chk("mid_rst_valid", 32'(resp_valid), 1);
      chk("mid_rst_err", 32'(resp_err), 1);
      chk("mid_rst_instr", 32'(resp_instr), 0);

      // Full-depth load with forced last at DEPTH-1
      tick();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 256; i++) begin
         load_valid = 1'b1;
         load_data  = 9'(i * 3 + 1);
         tick();
      end
      load_valid = 1'b0;
      settle();
      chk("full_prog_len", 32'(prog_len), 256);
      chk("full_run", 32'(load_ready), 0);
      chk("full_done", 32'(done), 0);
      req_valid = 1'b1;
      req_addr  = 8'd255;
      tick();
      req_valid = 1'b0;
      settle();
      chk("full_top_instr", 32'(resp_instr), 32'h0FE);
      chk("full_top_err", 32'(resp_err), 0);
      chk("parity_err_idle", 32'(parity_err), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_mem.md
Name: instr_fetch_mem

Overview:
Parametrised, loadable instruction store for the TinyChip core.
- A program is streamed in through a load port; the fetch stage reads it through a valid/ready request/response handshake.
- Read latency is one registered cycle, with response backpressure.
- Flags fetches beyond the loaded program length and drives a sticky done flag for the top level.

Parameters:
IW, 9, instruction width in bits
AW, 8, address width; DEPTH = 2**AW words
NOP_WORD, 9'b0, word returned on out-of-range fetch (width IW)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
load_start  input  1  begin a program load; load pointer goes to 0
load_valid  input  1  load_data valid this cycle
load_last  input  1  qualifies load_valid: final word of program
load_data  input  IW  instruction word to store
load_ready  output  1  high while in LOAD
req_valid  input  1  fetch request
req_addr  input  AW  fetch address
req_ready  output  1  request accepted when req_valid && req_ready
resp_valid  output  1  response available
resp_ready  input  1  consumer accepts the response
resp_instr  output  IW  fetched word
resp_addr  output  AW  address of resp_instr
resp_err  output  1  response was out of range (or parity fail)
prog_len  output  AW+1  number of loaded words
done  output  1  sticky: no program loaded, or out-of-range fetch seen

Behaviour:
- Reset (clk edge with reset==0):
  - state=IDLE; load pointer=0; prog_len=0.
  - resp_valid=0, resp_instr=0, resp_addr=0, resp_err=0, done=1.
  - RAM contents are not cleared.
- States: IDLE, LOAD, RUN.
  - IDLE --load_start--> LOAD
  - LOAD --accepted load_last, or write at ptr==DEPTH-1--> RUN
  - RUN --load_start--> LOAD
  - load_start in LOAD restarts the pointer at 0.
- LOAD:
  - load_ready=1. Each load_valid writes mem[ptr] and increments ptr.
  - The final word (load_last, or ptr==DEPTH-1 as forced last) sets prog_len=ptr+1 and clears done.
  - Entering LOAD sets prog_len=0 and done=1.
  - req_ready=0.
  - Any pending response is dropped (resp_valid=0).
- RUN:
  - req_ready = !load_start && (!resp_valid || resp_ready).
  - On an accepted request, the next cycle gives resp_valid=1, resp_addr=req_addr, and resp_instr=mem[req_addr].
  - If req_addr >= prog_len: resp_instr=NOP_WORD, resp_err=1, and done is set (sticky until the next load_start).
- Backpressure:
  - While resp_valid && !resp_ready, all resp_* outputs hold stable and req_ready=0.
  - A response is consumed on resp_valid && resp_ready.
  - A same-cycle new request is accepted, giving back-to-back throughput of 1 per cycle.
  - resp_valid falls after consumption if no new request arrives.
- Simultaneous load_start with req_valid in RUN: load_start wins, and the request is not accepted.
- Reset mid-load: prog_len=0, so all later fetches are out of range until a new load completes.
- Address arithmetic is unsigned. The ptr increment never wraps, because of the forced last at DEPTH-1.

Optional Feature:
INSTR_PARITY_EN
- Defined:
  - RAM word is IW+1 bits; even parity is computed on each write.
  - The read checks parity; on mismatch, resp_err=1 and output parity_err (1 bit, sticky until reset or load_start) is set.
  - resp_instr still carries the stored data.
- Undefined: no parity storage; parity_err is tied to 0.

Decomposition:
- Package instr_mem_pkg holds:
  - state enum (IDLE, LOAD, RUN)
  - default IW/AW localparams
  - NOP_WORD constant
  - even-parity function
- Sub-module instr_mem_array: simple dual-port RAM, synchronous write, synchronous 1-cycle read, parametrised width and depth.
- Control, handshake and flags stay in the top module.

Test Plan:
- Reset low for 2 cycles -> resp_valid=0, prog_len=0, done=1, load_ready=0, req_ready=0.
- load_start; load 9'h10F, 9'h10F, 9'h1AB, 9'h0A9 (last on 4th) -> prog_len=4, done=0, state RUN. Fetch addr 2 -> one cycle later resp_instr=9'h1AB, resp_addr=2, resp_err=0.
- Back-to-back fetches of addrs 0,1,2,3 with resp_ready=1 -> 4 responses on 4 consecutive cycles, in order.
- Hold resp_ready=0 for 3 cycles after fetching addr 1 -> resp_instr=9'h10F stable, req_ready=0; release -> next request accepted the same cycle.
- Fetch addr 4 with prog_len=4 -> resp_instr=NOP_WORD, resp_err=1, done=1 and stays 1; load_start -> done stays 1 until the new load completes.
- load_start asserted with req_valid in RUN -> request not accepted, state LOAD. Reset low mid-load -> prog_len=0, and a later fetch of addr 0 gives resp_err=1.
